// File: rtl/mod12_wrap_tracker_if.sv
// Bus between the observed mod-12 counter and its wrap tracker.
// Signal names mirror the tracker's port list; widths are parameters.
// Sampling rule: there is no valid/ready pair on this bus. Every rising
// clock edge is one sample of cnt_in together with the cnt_rst/cnt_load/
// cnt_mode/clr qualifiers that describe how that value was produced, so the
// producer must present a new, aligned tuple on every cycle.
interface mod12_wrap_tracker_if #(
  parameter int CW     = 4,
  parameter int WRAP_W = 8
);
  // Producer side (counter plus control)
  logic [CW-1:0]     cnt_in;
  logic              cnt_rst;
  logic              cnt_load;
  logic              cnt_mode;
  logic              clr;
  // Tracker results
  logic              wrap_pulse;
  logic              borrow_pulse;
  logic [WRAP_W-1:0] wrap_cnt;
  logic              err_range;
  logic              err_step;
  logic [1:0]        state;

  modport master (
    output cnt_in, cnt_rst, cnt_load, cnt_mode, clr,
    input  wrap_pulse, borrow_pulse, wrap_cnt, err_range, err_step, state
  );

  modport slave (
    input  cnt_in, cnt_rst, cnt_load, cnt_mode, clr,
    output wrap_pulse, borrow_pulse, wrap_cnt, err_range, err_step, state
  );
endinterface

// File: rtl/mod12_wrap_tracker.sv
// mod12_wrap_tracker: checks the count stream of a mod-MOD up/down loadable
// counter, flags out-of-range values and illegal steps, and turns legal
// wrap-arounds into carry/borrow pulses accumulated in an up/down counter.
// Optional feature macro: MOD12_WRAP_SAT_EN -- when defined the wrap
// accumulator saturates at 0 and 2^WRAP_W-1 instead of rolling over.
module mod12_wrap_tracker #(
  parameter int MOD    = 12,
  parameter int CW     = 4,
  parameter int WRAP_W = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  mod12_wrap_tracker_if.slave  bus
);

  typedef enum logic [1:0] {
    SYNC  = 2'd0,
    TRACK = 2'd1,
    FAULT = 2'd2
  } state_t;

  localparam logic [CW:0]   MOD_W = (CW+1)'(MOD);
  localparam logic [CW-1:0] LAST  = CW'(MOD - 1);

  state_t            state_q, state_d;
  logic [CW-1:0]     prev_q, prev_d;
  logic [WRAP_W-1:0] wrap_cnt_q, wrap_cnt_d;
  logic              wrap_pulse_q, wrap_pulse_d;
  logic              borrow_pulse_q, borrow_pulse_d;
  logic              err_range_q, err_range_d;
  logic              err_step_q, err_step_d;

  logic              in_range;
  logic [CW-1:0]     exp_up;
  logic [CW-1:0]     exp_dn;
  logic [WRAP_W-1:0] wrap_inc;
  logic [WRAP_W-1:0] wrap_dec;

  // Legal successor values of prev and the accumulator's step results
  always_comb begin
    in_range = ({1'b0, bus.cnt_in} < MOD_W);
    exp_up   = (prev_q == LAST) ? '0 : prev_q + CW'(1);
    exp_dn   = (prev_q == '0) ? LAST : prev_q - CW'(1);
`ifdef MOD12_WRAP_SAT_EN
    wrap_inc = (wrap_cnt_q == '1) ? wrap_cnt_q : wrap_cnt_q + WRAP_W'(1);
    wrap_dec = (wrap_cnt_q == '0) ? wrap_cnt_q : wrap_cnt_q - WRAP_W'(1);
`else
    wrap_inc = wrap_cnt_q + WRAP_W'(1);
    wrap_dec = wrap_cnt_q - WRAP_W'(1);
`endif
  end

  // Next-state logic: clr, then range, then cnt_rst, cnt_load, step check
  always_comb begin
    state_d        = state_q;
    prev_d         = prev_q;
    wrap_cnt_d     = wrap_cnt_q;
    wrap_pulse_d   = 1'b0;
    borrow_pulse_d = 1'b0;
    err_range_d    = err_range_q;
    err_step_d     = err_step_q;

    if (bus.clr) begin
      err_range_d = 1'b0;
      err_step_d  = 1'b0;
      wrap_cnt_d  = '0;
      state_d     = SYNC;
    end else begin
      unique case (state_q)
        SYNC: begin
          if (!in_range) begin
            err_range_d = 1'b1;
            state_d     = FAULT;
          end else begin
            prev_d  = bus.cnt_in;
            state_d = TRACK;
          end
        end
        TRACK: begin
          if (!in_range) begin
            err_range_d = 1'b1;
            state_d     = FAULT;
          end else if (bus.cnt_rst) begin
            // A counter reset must land on zero; load is ignored alongside it
            if (bus.cnt_in == '0) begin
              prev_d = '0;
            end else begin
              err_step_d = 1'b1;
              state_d    = FAULT;
            end
          end else if (bus.cnt_load) begin
            prev_d = bus.cnt_in;
          end else if (bus.cnt_mode) begin
            if (bus.cnt_in == exp_up) begin
              prev_d = bus.cnt_in;
              if (prev_q == LAST) begin
                wrap_pulse_d = 1'b1;
                wrap_cnt_d   = wrap_inc;
              end
            end else begin
              err_step_d = 1'b1;
              state_d    = FAULT;
            end
          end else begin
            if (bus.cnt_in == exp_dn) begin
              prev_d = bus.cnt_in;
              if (prev_q == '0) begin
                borrow_pulse_d = 1'b1;
                wrap_cnt_d     = wrap_dec;
              end
            end else begin
              err_step_d = 1'b1;
              state_d    = FAULT;
            end
          end
        end
        FAULT: begin
          // Frozen until clr or reset
        end
        default: state_d = SYNC;
      endcase
    end
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= SYNC;
      prev_q         <= '0;
      wrap_cnt_q     <= '0;
      wrap_pulse_q   <= 1'b0;
      borrow_pulse_q <= 1'b0;
      err_range_q    <= 1'b0;
      err_step_q     <= 1'b0;
    end else begin
      state_q        <= state_d;
      prev_q         <= prev_d;
      wrap_cnt_q     <= wrap_cnt_d;
      wrap_pulse_q   <= wrap_pulse_d;
      borrow_pulse_q <= borrow_pulse_d;
      err_range_q    <= err_range_d;
      err_step_q     <= err_step_d;
    end
  end

  assign bus.wrap_pulse   = wrap_pulse_q;
  assign bus.borrow_pulse = borrow_pulse_q;
  assign bus.wrap_cnt     = wrap_cnt_q;
  assign bus.err_range    = err_range_q;
  assign bus.err_step     = err_step_q;
  assign bus.state        = state_q;

endmodule
